// File: rtl/wb_struct_pkg.sv
// Shared encodings for the Wishbone slave memory responder: FSM states, bus direction, LFSR constants.
// Single-cycle helper function only; no state held here.
package wb_struct_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_WAIT = 2'd1;
   localparam state_t ST_RESP = 2'd2;

   localparam logic WB_READ  = 1'b0;
   localparam logic WB_WRITE = 1'b1;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
   endfunction

endpackage

// File: rtl/wb_slv_lfsr.sv
// 16-bit Galois LFSR supplying random wait-state jitter; steps one position per advance pulse.
// Present only in builds with WB_SLV_RAND_WAIT_EN; no backpressure, value is registered.
module wb_slv_lfsr
   import wb_struct_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        advance,
   output logic [15:0] value
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         value <= LFSR_SEED;
      end else if (advance) begin
         value <= lfsr_step(value);
      end
   end

endmodule

// File: rtl/wb_slave_mem_responder.sv
// Wishbone classic slave memory: termination 1+W cycles after request, err on bad address, abort on stb drop.
// WB_SLV_RAND_WAIT_EN adds 0..3 pseudo-random wait cycles per accepted request.
module wb_slave_mem_responder
   import wb_struct_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    SEL_WIDTH   = 4,
   parameter int                    MEM_WORDS   = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                    WAIT_STATES = 0
)(
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_n_i,
   input  logic [ADDR_WIDTH-1:0] wb_adr_i,
   input  logic [DATA_WIDTH-1:0] wb_dat_i,
   input  logic [SEL_WIDTH-1:0]  wb_sel_i,
   input  logic                  wb_we_i,
   input  logic                  wb_cyc_i,
   input  logic                  wb_stb_i,
   output logic [DATA_WIDTH-1:0] wb_dat_o,
   output logic                  wb_ack_o,
   output logic                  wb_err_o
);

   localparam int                IDX_W = $clog2(MEM_WORDS);
   localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(MEM_WORDS) << 2;

   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

   state_t                state;
   logic [4:0]            cnt;
   logic [ADDR_WIDTH-1:0] adr_q;
   logic [DATA_WIDTH-1:0] dat_q;
   logic [SEL_WIDTH-1:0]  sel_q;
   logic                  we_q;

   logic                  req;
   logic                  in_idle;
   logic [4:0]            w_eff;
   logic                  enter_resp;
   logic [ADDR_WIDTH-1:0] acc_adr;
   logic [DATA_WIDTH-1:0] acc_dat;
   logic [SEL_WIDTH-1:0]  acc_sel;
   logic                  acc_we;
   logic [ADDR_WIDTH-1:0] acc_off;
   logic                  acc_ok;
   logic [IDX_W-1:0]      acc_idx;

   assign req     = wb_cyc_i & wb_stb_i;
   assign in_idle = (state == ST_IDLE);

`ifdef WB_SLV_RAND_WAIT_EN
   logic [15:0] lfsr_val;
   logic        unused_lfsr;

   wb_slv_lfsr u_lfsr (
      .clk     (wb_clk_i),
      .rst_n   (wb_rst_n_i),
      .advance (in_idle & req),
      .value   (lfsr_val)
   );

   assign unused_lfsr = ^lfsr_val[15:2];
   assign w_eff       = 5'(WAIT_STATES) + {3'b000, lfsr_val[1:0]};
`else
   assign w_eff = 5'(WAIT_STATES);
`endif

   // With no wait states the access resolves straight from the live bus; otherwise from the latched request.
   assign acc_adr = in_idle ? wb_adr_i : adr_q;
   assign acc_dat = in_idle ? wb_dat_i : dat_q;
   assign acc_sel = in_idle ? wb_sel_i : sel_q;
   assign acc_we  = in_idle ? wb_we_i  : we_q;

   assign enter_resp = req && ((in_idle && (w_eff == 5'd0)) ||
                               ((state == ST_WAIT) && (cnt == 5'd1)));

   assign acc_off = acc_adr - BASE_ADDR;
   assign acc_ok  = (acc_adr[1:0] == 2'b00) && (acc_adr >= BASE_ADDR) &&
                    ({1'b0, acc_off} < SPAN);
   assign acc_idx = acc_off[IDX_W+1:2];

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         adr_q    <= '0;
         dat_q    <= '0;
         sel_q    <= '0;
         we_q     <= WB_READ;
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;
         wb_dat_o <= '0;
      end else begin
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (req) begin
                  adr_q <= wb_adr_i;
                  dat_q <= wb_dat_i;
                  sel_q <= wb_sel_i;
                  we_q  <= wb_we_i;
                  cnt   <= w_eff;
                  state <= (w_eff != 5'd0) ? ST_WAIT : ST_RESP;
               end
            end
            ST_WAIT: begin
               if (!req) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt - 5'd1;
                  if (cnt == 5'd1) begin
                     state <= ST_RESP;
                  end
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase

         if (enter_resp) begin
            wb_ack_o <= acc_ok;
            wb_err_o <= !acc_ok;
            if (acc_ok && (acc_we == WB_READ)) begin
               wb_dat_o <= mem[acc_idx];
            end
         end
      end
   end

   // Contents survive reset; only the write strobe is gated by it.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_n_i && enter_resp && acc_ok && (acc_we == WB_WRITE)) begin
         for (int k = 0; k < SEL_WIDTH; k++) begin
            if (acc_sel[k]) begin
               mem[acc_idx][8*k +: 8] <= acc_dat[8*k +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_wb_slave_mem_responder.sv
// Randomized bench for two responder instances (no-wait at base 0, three-wait at base 0x400) against a word-array model.
module tb_wb_slave_mem_responder;

`ifdef WB_SLV_RAND_WAIT_EN
   localparam int RAND_EXTRA = 3;
`else
   localparam int RAND_EXTRA = 0;
`endif

   logic        clk;
   logic        rst_n;
   logic [31:0] adr   [2];
   logic [31:0] wdat  [2];
   logic [3:0]  sel   [2];
   logic        we    [2];
   logic        cyc   [2];
   logic        stb   [2];
   logic [31:0] rdat  [2];
   logic        ack   [2];
   logic        err   [2];

   int n_chk  = 0;
   int n_pass = 0;

   logic [31:0] mdl     [2][16];
   logic [31:0] last_rd [2];

   wb_slave_mem_responder #(
      .MEM_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)
   ) dut0 (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(adr[0]), .wb_dat_i(wdat[0]),
      .wb_sel_i(sel[0]), .wb_we_i(we[0]), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]),
      .wb_dat_o(rdat[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0])
   );

   wb_slave_mem_responder #(
      .MEM_WORDS(64), .BASE_ADDR(32'h0000_0400), .WAIT_STATES(3)
   ) dut1 (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(adr[1]), .wb_dat_i(wdat[1]),
      .wb_sel_i(sel[1]), .wb_we_i(we[1]), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]),
      .wb_dat_o(rdat[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int ws(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   function automatic longint base_of(input int d);
      return (d == 0) ? 64'h0 : 64'h400;
   endfunction

   function automatic longint words_of(input int d);
      return (d == 0) ? 1024 : 64;
   endfunction

   function automatic logic is_valid(input int d, input logic [31:0] a);
      longint la;
      la = a;
      return (a[1:0] == 2'b00) && (la >= base_of(d)) && (la < base_of(d) + 4 * words_of(d));
   endfunction

   function automatic logic [31:0] word_addr(input int d, input int ix);
      return 32'(base_of(d) + 4 * ix);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   task automatic drive(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] dd, input logic [3:0] s);
      adr[d] = a; wdat[d] = dd; sel[d] = s; we[d] = w; cyc[d] = 1'b1; stb[d] = 1'b1;
   endtask

   task automatic release_bus(input int d);
      cyc[d] = 1'b0; stb[d] = 1'b0;
   endtask

   // Called #1 after a clock edge; returns #1 after the edge that ends the beat.
   task automatic xfer(input int d, input logic w, input logic [31:0] a,
                       input logic [31:0] dd, input logic [3:0] s);
      int     lat;
      logic   v;
      longint ix;
      v  = is_valid(d, a);
      ix = (longint'(a) - base_of(d)) / 4;
      drive(d, w, a, dd, s);
      @(posedge clk); #1;
      lat = 0;
      while (!(ack[d] | err[d]) && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      if (v && ix < 16) begin
         if (w) begin
            for (int k = 0; k < 4; k++)
               if (s[k]) mdl[d][ix][8*k +: 8] = dd[8*k +: 8];
         end else begin
            last_rd[d] = mdl[d][ix];
         end
      end
      check("term", 32'(ack[d] | err[d]), 32'd1);
      if (RAND_EXTRA == 0) check("latency", 32'(lat), 32'(ws(d)));
      else check("latency", 32'((lat >= ws(d)) && (lat <= ws(d) + RAND_EXTRA)), 32'd1);
      check("ack", 32'(ack[d]), 32'(v));
      check("err", 32'(err[d]), 32'(!v));
      check("dat_o", rdat[d], last_rd[d]);
      @(posedge clk); #1;
      check("pulse", 32'(ack[d] | err[d]), 32'd0);
      release_bus(d);
   endtask

   initial begin
      int          d;
      int          r;
      int          ix;
      logic        seen;
      logic [31:0] a;

      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         adr[i] = '0; wdat[i] = '0; sel[i] = '0; we[i] = 1'b0;
         cyc[i] = 1'b0; stb[i] = 1'b0; last_rd[i] = '0;
         for (int j = 0; j < 16; j++) mdl[i][j] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         check("rst_ack", 32'(ack[i]), 32'd0);
         check("rst_err", 32'(err[i]), 32'd0);
         check("rst_dat", rdat[i], 32'd0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 16; j++)
            xfer(i, 1'b1, word_addr(i, j), $urandom, 4'hF);

      xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      xfer(0, 1'b0, 32'h10, 32'h0, 4'hF);
      check("rd_deadbeef", rdat[0], 32'hDEADBEEF);

      xfer(0, 1'b1, 32'h20, 32'h11223344, 4'hF);
      xfer(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
      xfer(0, 1'b0, 32'h20, 32'h0, 4'h0);
      check("rd_merge", rdat[0], 32'h11BB33DD);

      xfer(0, 1'b1, 32'h24, $urandom, 4'h0);
      xfer(0, 1'b0, 32'h24, 32'h0, 4'hF);

      xfer(0, 1'b0, 32'h1002, 32'h0, 4'hF);
      xfer(0, 1'b0, 32'h1000, 32'h0, 4'hF);
      xfer(0, 1'b1, 32'h1000, 32'h55555555, 4'hF);
      xfer(0, 1'b0, 32'h20, 32'h0, 4'hF);
      check("rd_after_err", rdat[0], 32'h11BB33DD);
      xfer(1, 1'b0, 32'h3FC, 32'h0, 4'hF);
      xfer(1, 1'b1, 32'h500, 32'h0, 4'hF);
      xfer(1, 1'b0, 32'h401, 32'h0, 4'hF);

      // Abandoned write: stb dropped while the three-wait instance is still waiting.
      drive(1, 1'b1, word_addr(1, 5), ~mdl[1][5], 4'hF);
      @(posedge clk); @(posedge clk); #1;
      release_bus(1);
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         seen = seen | ack[1] | err[1];
      end
      check("abort_quiet", 32'(seen), 32'd0);
      xfer(1, 1'b0, word_addr(1, 5), 32'h0, 4'hF);
      xfer(1, 1'b0, word_addr(1, 7), 32'h0, 4'hF);

      // Reset mid-wait discards the write and clears the outputs.
      drive(1, 1'b1, word_addr(1, 6), ~mdl[1][6], 4'hF);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_ack", 32'(ack[1]), 32'd0);
      check("mid_rst_err", 32'(err[1]), 32'd0);
      check("mid_rst_dat", rdat[1], 32'd0);
      check("mid_rst_dat0", rdat[0], 32'd0);
      last_rd[0] = '0;
      last_rd[1] = '0;
      release_bus(1);
      rst_n = 1'b1;
      @(posedge clk); #1;
      xfer(1, 1'b0, word_addr(1, 6), 32'h0, 4'hF);

      for (int n = 0; n < 200; n++) begin
         d  = int'($urandom_range(0, 1));
         r  = int'($urandom_range(0, 9));
         ix = int'($urandom_range(0, 15));
         case (r)
            0:       a = word_addr(d, ix) + 32'($urandom_range(1, 3));
            1:       a = 32'(base_of(d) + 4 * words_of(d)) + 32'(4 * ix);
            2:       a = (d == 1) ? 32'(base_of(d) - 4 * (ix + 1)) : 32'hFFFF_FFFC;
            default: a = word_addr(d, ix);
         endcase
         xfer(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
